// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and helpers for the GPU frame-level control blocks.
//   frame_state_t : frame sequencer states (IDLE, CLEAR, MATRIX, RENDER, DONE)
//   count_max     : all-ones value for a counter of the given width (up to 32)
//   sat_inc       : increment that holds at a ceiling instead of wrapping
package gpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    MATRIX = 3'd2,
    RENDER = 3'd3,
    DONE   = 3'd4
  } frame_state_t;

  function automatic logic [31:0] count_max(input int width);
    logic [31:0] result;
    if (width >= 32) begin
      result = 32'hFFFF_FFFF;
    end else begin
      result = (32'd1 << width) - 32'd1;
    end
    return result;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    logic [31:0] result;
    if (value >= max_value) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: free-running frame period counter.
//   clk  in  gpu clock
//   rst  in  synchronous active-high reset (counter returns to 0)
//   tick out high for the single cycle in which the counter holds FRAME_PERIOD-1
module frame_timer #(
  parameter int FRAME_PERIOD = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int TW = $clog2(FRAME_PERIOD);
  localparam logic [TW-1:0] LAST = TW'(FRAME_PERIOD - 1);

  logic [TW-1:0] timer;

  assign tick = (timer == LAST);

  // Period counter: 0..FRAME_PERIOD-1, wrapping on the tick cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: frame-level sequencer for the GPU pipeline.
// On every frame tick it switches/clears the framebuffer, waits out a guard
// window and framebuffer readiness, requests a new view matrix, and releases
// vertex fetch from reset once the matrix is loaded. Frame, pixel and overrun
// counts are kept for the debug display.
//   clk_in, rst_in          clock and synchronous active-high reset
//   framebuffer_ready_in    framebuffer accepting pixels (low while clearing)
//   matrix_valid_in         new matrix delivered (pulse)
//   render_done_in          pipeline drained for the current frame
//   pixel_valid_in          fragment shader wrote a pixel
//   framebuffer_switch_out  one-cycle pulse after each tick
//   framebuffer_clear_out   one-cycle pulse after each tick, high in reset
//   matrix_start_out        one-cycle request to matrix_gen
//   fetch_rst_out           vertex_fetch reset, low only while rendering
//   busy_out                frame in progress (not IDLE / DONE)
//   frame/pixel/overrun_count_out  debug counters (registered)
module frame_scheduler
  import gpu_pkg::*;
#(
  parameter int FRAME_PERIOD = 2_000_000,
  parameter int CLEAR_GUARD  = 100,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   framebuffer_ready_in,
  input  logic                   matrix_valid_in,
  input  logic                   render_done_in,
  input  logic                   pixel_valid_in,
  output logic                   framebuffer_switch_out,
  output logic                   framebuffer_clear_out,
  output logic                   matrix_start_out,
  output logic                   fetch_rst_out,
  output logic                   busy_out,
  output logic [COUNT_WIDTH-1:0] frame_count_out,
  output logic [COUNT_WIDTH-1:0] pixel_count_out,
  output logic [COUNT_WIDTH-1:0] overrun_count_out
);

  localparam int GW = $clog2(CLEAR_GUARD + 1);
  localparam logic [GW-1:0] GUARD_MAX = GW'(CLEAR_GUARD);
  localparam logic [31:0] CNT_MAX = count_max(COUNT_WIDTH);

  frame_state_t state, next_state;
  logic [GW-1:0] guard, next_guard;
  logic [COUNT_WIDTH-1:0] pixel_live, next_pixel_live, pixel_sum;
  logic [COUNT_WIDTH-1:0] next_frame_count, next_pixel_count, next_overrun_count;
  logic next_switch, next_clear, next_matrix_start, next_fetch_rst, next_busy;
  logic tick;

  frame_timer #(
    .FRAME_PERIOD(FRAME_PERIOD)
  ) u_timer (
    .clk (clk_in),
    .rst (rst_in),
    .tick(tick)
  );

  // Next-state, counter and output decode for the frame sequencer.
  always_comb begin
    next_state         = state;
    next_guard         = guard;
    next_pixel_live    = pixel_live;
    next_frame_count   = frame_count_out;
    next_pixel_count   = pixel_count_out;
    next_overrun_count = overrun_count_out;
    next_switch        = 1'b0;
    next_clear         = 1'b0;
    next_matrix_start  = 1'b0;
    pixel_sum          = pixel_live;

    // Live pixel total including this cycle's pixel, so a pixel landing on
    // the tick cycle still makes it into the latched count.
    if ((state == RENDER || state == DONE) && pixel_valid_in) begin
      pixel_sum = COUNT_WIDTH'(sat_inc(32'(pixel_live), CNT_MAX));
    end else begin
      pixel_sum = pixel_live;
    end

    if (tick) begin
      // A tick preempts everything, including render_done in the same cycle.
      next_switch     = 1'b1;
      next_clear      = 1'b1;
      next_guard      = '0;
      next_state      = CLEAR;
      next_pixel_live = '0;
      if (state != IDLE) begin
        next_pixel_count = pixel_sum;
      end else begin
        next_pixel_count = pixel_count_out;
      end
      if ((state == CLEAR || state == MATRIX || state == RENDER) && !render_done_in) begin
        next_overrun_count = COUNT_WIDTH'(sat_inc(32'(overrun_count_out), CNT_MAX));
      end else begin
        next_overrun_count = overrun_count_out;
      end
    end else begin
      next_pixel_live = pixel_sum;
      case (state)
        IDLE: begin
          next_state = IDLE;
        end
        CLEAR: begin
          // Readiness is ignored during the guard window right after the
          // clear, while the framebuffer may not yet have dropped ready.
          if (guard >= GUARD_MAX && framebuffer_ready_in) begin
            next_matrix_start = 1'b1;
            next_state        = MATRIX;
          end else if (guard < GUARD_MAX) begin
            next_guard = guard + GW'(1);
          end else begin
            next_guard = guard;
          end
        end
        MATRIX: begin
          if (matrix_valid_in) begin
            next_state       = RENDER;
            next_frame_count = frame_count_out + COUNT_WIDTH'(1);
          end else begin
            next_state = MATRIX;
          end
        end
        RENDER: begin
          if (render_done_in) begin
            next_state = DONE;
          end else begin
            next_state = RENDER;
          end
        end
        DONE: begin
          next_state = DONE;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end

    next_fetch_rst = !(next_state == RENDER || next_state == DONE);
    next_busy      = !(next_state == IDLE || next_state == DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                  <= IDLE;
      guard                  <= '0;
      pixel_live             <= '0;
      framebuffer_switch_out <= 1'b0;
      framebuffer_clear_out  <= 1'b1;
      matrix_start_out       <= 1'b0;
      fetch_rst_out          <= 1'b1;
      busy_out               <= 1'b0;
      frame_count_out        <= '0;
      pixel_count_out        <= '0;
      overrun_count_out      <= '0;
    end else begin
      state                  <= next_state;
      guard                  <= next_guard;
      pixel_live             <= next_pixel_live;
      framebuffer_switch_out <= next_switch;
      framebuffer_clear_out  <= next_clear;
      matrix_start_out       <= next_matrix_start;
      fetch_rst_out          <= next_fetch_rst;
      busy_out               <= next_busy;
      frame_count_out        <= next_frame_count;
      pixel_count_out        <= next_pixel_count;
      overrun_count_out      <= next_overrun_count;
    end
  end

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Frame-level sequencer for the GPU pipeline. Generates the periodic frame tick. On each tick it issues framebuffer switch/clear. It then waits for the cleared buffer to become ready, requests a new view matrix and holds vertex fetch in reset until that matrix is loaded. It also counts frames, pixels and overruns for the seven-segment debug display. It sits between the control logic (camera vectors), `matrix_gen`, `vertex_fetch` and `framebuffer`.

## Interface
- FRAME_PERIOD, 2_000_000, cycles between frame ticks (≥ CLEAR_GUARD+4)
- CLEAR_GUARD, 100, cycles after a tick during which framebuffer_ready_in is ignored
- COUNT_WIDTH, 16, width of all count outputs
- clk_in  in  1  gpu clock; single clock domain
- rst_in  in  1  synchronous, active-high reset
- framebuffer_ready_in  in  1  framebuffer accepting pixels (low while clearing)
- matrix_valid_in  in  1  matrix_gen has delivered the new matrix (pulse)
- render_done_in  in  1  pipeline drained for the current frame (level or pulse)
- pixel_valid_in  in  1  fragment shader wrote a pixel
- framebuffer_switch_out  out  1  one-cycle pulse on tick
- framebuffer_clear_out  out  1  one-cycle pulse on tick; held high during reset
- matrix_start_out  out  1  one-cycle request to matrix_gen
- fetch_rst_out  out  1  vertex_fetch reset; high except while rendering
- busy_out  out  1  state ∉ {IDLE, DONE}
- frame_count_out  out  COUNT_WIDTH  frames started, wraps
- pixel_count_out  out  COUNT_WIDTH  pixels of last completed frame, saturating
- overrun_count_out  out  COUNT_WIDTH  ticks arriving before render_done, saturating

## Operation
- Timer: counts 0..FRAME_PERIOD-1 from reset; tick = (timer == FRAME_PERIOD-1); wraps to 0.
- States: IDLE, CLEAR, MATRIX, RENDER, DONE.
- IDLE: reset state; on tick → CLEAR.
- Every tick, in any state: pulse switch_out and clear_out the same cycle; guard counter := 0; → CLEAR.
  - If state ∈ {CLEAR, MATRIX, RENDER} and render_done_in is low that cycle, overrun_count_out +1 (saturating).
  - Latch live pixel counter (including any pixel_valid_in on the tick cycle) into pixel_count_out, then zero it.
  - Ticks while in IDLE neither latch nor count an overrun.
- CLEAR: guard counter increments each cycle. Once guard ≥ CLEAR_GUARD and framebuffer_ready_in = 1, pulse matrix_start_out → MATRIX.
- MATRIX: on matrix_valid_in → RENDER; frame_count_out +1 (wrapping) on the transition.
- RENDER: fetch_rst_out = 0; on render_done_in → DONE.
- DONE: fetch_rst_out = 0; wait for tick.
- Pixel counting: live counter increments on pixel_valid_in in RENDER and DONE only, saturating at 2^COUNT_WIDTH-1.
- matrix_valid_in outside MATRIX and render_done_in outside RENDER are ignored.

## Timing
- All outputs are registered.
- Reset values: switch_out 0, clear_out 1, matrix_start_out 0, fetch_rst_out 1, busy_out 0, all counts 0, timer 0.
- Tick at timer cycle T: switch/clear pulses are visible at T+1.
- matrix_start_out is high exactly 1 cycle, the cycle after the CLEAR exit condition is sampled true. This is never earlier than tick+CLEAR_GUARD+1.
- fetch_rst_out falls the cycle after matrix_valid_in is sampled in MATRIX. It rises the cycle after a tick.
- Tick and render_done_in in the same RENDER cycle: no overrun; tick wins → CLEAR.
- rst_in mid-frame: all state and outputs return to reset values on the next edge.

## Structure
- Shared `gpu_pkg`: `frame_state_t` enum (IDLE, CLEAR, MATRIX, RENDER, DONE); saturating-increment function for count widths.
- Sub-module `frame_timer` (period counter, tick output).
- The remainder is one FSM plus counters.
- Replaces the inline frame FSM in the top level.

## Test plan
Bench parameters: FRAME_PERIOD=1000, CLEAR_GUARD=10.
- Reset, then idle 999 cycles → switch_out/clear_out pulse once; fetch_rst_out stays 1; counts 0.
- After tick: ready_in held low 40 cycles, then high; matrix_valid_in 5 cycles after matrix_start_out → exactly one matrix_start_out pulse after ready rises; fetch_rst_out 0 one cycle after matrix_valid_in; frame_count_out=1.
- ready_in high throughout → matrix_start_out no earlier than tick+11.
- 37 pixel_valid_in pulses during RENDER, render_done_in, next tick → pixel_count_out=37, overrun_count_out=0; pixels pulsed in CLEAR are not counted.
- render_done_in withheld for two frames → overrun_count_out=2; frame_count_out still increments each frame.
- matrix_valid_in withheld across a tick → overrun=1, new switch/clear pulse, guard restarts.
- rst_in mid-RENDER → fetch_rst_out=1, counts 0, state IDLE on the next cycle.
